// File: rtl/uart_rx.sv
// UART receive stage: oversampled start detect, 3-sample majority vote per bit,
// 8 data bits LSB first, even parity, stop check, valid/ready holding register
// and registered clear-to-send toward the peer transmitter.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic       rx_i,
  input  logic       rx_enable_i,
  output logic       rx_cts_n_o,
  output logic [7:0] rx_d_o,
  output logic       rx_d_valid_o,
  input  logic       rx_d_ready_i,
  output logic       rx_perr_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  input  logic       clear_err_i
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] VoteA   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] VoteB   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] VoteC   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] TcntMax = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TcntOne = TW'(1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync2_q, rx_p_q;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [3:0]      bcnt_q, bcnt_d;
  logic [1:0]      samp_q, samp_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            pbit_q, pbit_d;
  logic [7:0]      rx_d_q, rx_d_d;
  logic            valid_q, valid_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            cts_n_q;
  logic            rx_s, vote, pop;

  assign rx_s = sync2_q;
  assign pop  = valid_q & rx_d_ready_i;
  // Majority of the two stored samples and the live third sample.
  assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

  // Next-state: frame FSM, bit sampling, holding register and sticky flags.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    samp_d  = samp_q;
    shreg_d = shreg_q;
    pbit_d  = pbit_q;
    rx_d_d  = rx_d_q;
    perr_d  = perr_q;
    valid_d = valid_q & ~rx_d_ready_i;
    ferr_d  = ferr_q & ~clear_err_i;
    ovr_d   = ovr_q & ~clear_err_i;

    if (!rx_enable_i) begin
      state_d = StIdle;
      tcnt_d  = '0;
    end else if (tick_i) begin
      if (state_q == StIdle) begin
        tcnt_d = '0;
        // The edge tick itself counts as tick 0 of the start bit.
        if (rx_p_q && !rx_s) begin
          state_d = StStart;
          tcnt_d  = TcntOne;
        end
      end else begin
        tcnt_d = (tcnt_q == TcntMax) ? '0 : tcnt_q + 1'b1;
        if (tcnt_q == VoteA) samp_d[0] = rx_s;
        if (tcnt_q == VoteB) samp_d[1] = rx_s;
        if (tcnt_q == VoteC) begin
          case (state_q)
            StStart: begin
              if (vote) begin
                state_d = StIdle;
                tcnt_d  = '0;
              end else begin
                state_d = StData;
                bcnt_d  = '0;
              end
            end
            StData: begin
              shreg_d = {vote, shreg_q[7:1]};
              bcnt_d  = bcnt_q + 4'd1;
              if (bcnt_q == 4'd7) state_d = StParity;
            end
            StParity: begin
              pbit_d  = vote;
              state_d = StStop;
            end
            StStop: begin
              // Rest of the stop bit is spent in idle so a back-to-back start edge is caught.
              state_d = StIdle;
              tcnt_d  = '0;
              if (!vote) begin
                ferr_d = 1'b1;
              end else if (valid_q && !pop) begin
                ovr_d = 1'b1;
              end else begin
                rx_d_d  = shreg_q;
                perr_d  = pbit_q ^ (^shreg_q);
                valid_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      rx_p_q  <= 1'b1;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      samp_q  <= '0;
      shreg_q <= '0;
      pbit_q  <= 1'b0;
      rx_d_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cts_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      if (tick_i) rx_p_q <= rx_s;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      samp_q  <= samp_d;
      shreg_q <= shreg_d;
      pbit_q  <= pbit_d;
      rx_d_q  <= rx_d_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      cts_n_q <= valid_q | ~rx_enable_i;
    end
  end

  assign rx_d_o       = rx_d_q;
  assign rx_d_valid_o = valid_q;
  assign rx_perr_o    = perr_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
  assign rx_cts_n_o   = cts_n_q;

endmodule
